nand_stim_checker: RTL

Self-checking stimulus stage that sits directly upstream of the switch-level NAND cell: it drives the cell's `A`/`B` inputs through all four input combinations and checks the returned `Vout` against the NAND truth table. Each vector is held for a fixed number of clock cycles and `Vout` is sampled after a settle window. A run ends with a latched pass/fail verdict and a saturating error count. This lets the NAND cell be exercised inside a clocked environment instead of a hand-written delay sequence.

---
 rtl/nand_stim_checker_if.sv | 26 ++
 rtl/nand_stim_checker.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/nand_stim_checker_if.sv
// Handshake bundle between the NAND stimulus/checker stage and its environment.
// The master side drives start and returns the cell output; the slave is the checker.
interface nand_stim_checker_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             vout;
    logic             a;
    logic             b;
    logic [1:0]       vec_idx;
    logic             busy;
    logic             done;
    logic             pass;
    logic             mismatch;
    logic [ERR_W-1:0] err_count;

    modport master (
        output start, vout,
        input  a, b, vec_idx, busy, done, pass, mismatch, err_count
    );

    modport slave (
        input  start, vout,
        output a, b, vec_idx, busy, done, pass, mismatch, err_count
    );
endinterface

// File: rtl/nand_stim_checker.sv
// Clocked stimulus stage for a NAND cell: walks {a,b} through 00..11 for LOOPS passes,
// samples vout after a settle window and latches a pass/fail verdict with a saturating error count.
module nand_stim_checker #(
    parameter int HOLD_CYCLES   = 10,
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    nand_stim_checker_if.slave bus
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int LW = $clog2(LOOPS + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_AT = CW'(SETTLE_CYCLES);
    localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_APPLY, S_DONE} state_t;

    state_t           r_state, w_state;
    logic [CW-1:0]    r_hold, w_hold;
    logic [LW-1:0]    r_loop, w_loop;
    logic [1:0]       r_vec, w_vec;
    logic             r_a, w_a;
    logic             r_b, w_b;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_pass, w_pass;
    logic             r_mis, w_mis;
    logic [ERR_W-1:0] r_err, w_err;
    logic             w_fail;
    logic [1:0]       w_vec_inc;

    // Next-state and next-output logic for the run sequencer
    always_comb begin
        w_state   = r_state;
        w_hold    = r_hold;
        w_loop    = r_loop;
        w_vec     = r_vec;
        w_a       = r_a;
        w_b       = r_b;
        w_busy    = r_busy;
        w_done    = r_done;
        w_pass    = r_pass;
        w_mis     = 1'b0;
        w_err     = r_err;
        w_vec_inc = r_vec + 2'd1;
        // Case-inequality so X/Z returned by the cell also counts as a failure
        w_fail    = (r_state == S_APPLY) && (r_hold == SETTLE_AT) && (bus.vout !== ~(r_a & r_b));

        if (w_fail) begin
            w_mis = 1'b1;
            if (r_err != ERR_MAX) begin
                w_err = r_err + ERR_W'(1);
            end else begin
                w_err = r_err;
            end
        end else begin
            w_mis = 1'b0;
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state = S_WARMUP;
                    w_hold  = {CW{1'b0}};
                    w_loop  = {LW{1'b0}};
                    w_vec   = 2'd0;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_pass  = 1'b0;
                    w_err   = {ERR_W{1'b0}};
                end else begin
                    w_state = r_state;
                end
            end
            S_WARMUP: begin
                if (r_hold == HOLD_LAST) begin
                    w_state = S_APPLY;
                    w_hold  = {CW{1'b0}};
                    w_vec   = 2'd0;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                end else begin
                    w_hold  = r_hold + CW'(1);
                end
            end
            S_APPLY: begin
                if (r_hold != HOLD_LAST) begin
                    w_hold = r_hold + CW'(1);
                end else if (r_vec != 2'd3) begin
                    w_hold = {CW{1'b0}};
                    w_vec  = w_vec_inc;
                    w_a    = w_vec_inc[1];
                    w_b    = w_vec_inc[0];
                end else if (r_loop != LOOP_LAST) begin
                    w_hold = {CW{1'b0}};
                    w_vec  = 2'd0;
                    w_a    = 1'b0;
                    w_b    = 1'b0;
                    w_loop = r_loop + LW'(1);
                end else begin
                    w_state = S_DONE;
                    w_hold  = {CW{1'b0}};
                    w_vec   = 2'd0;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = (w_err == {ERR_W{1'b0}});
                end
            end
            default: begin
                w_state = S_IDLE;
                w_hold  = {CW{1'b0}};
                w_loop  = {LW{1'b0}};
                w_vec   = 2'd0;
                w_a     = 1'b0;
                w_b     = 1'b0;
                w_busy  = 1'b0;
                w_done  = 1'b0;
                w_pass  = 1'b0;
                w_mis   = 1'b0;
                w_err   = {ERR_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hold  <= {CW{1'b0}};
            r_loop  <= {LW{1'b0}};
            r_vec   <= 2'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_mis   <= 1'b0;
            r_err   <= {ERR_W{1'b0}};
        end else begin
            r_state <= w_state;
            r_hold  <= w_hold;
            r_loop  <= w_loop;
            r_vec   <= w_vec;
            r_a     <= w_a;
            r_b     <= w_b;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_mis   <= w_mis;
            r_err   <= w_err;
        end
    end

    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.vec_idx   = r_vec;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.mismatch  = r_mis;
    assign bus.err_count = r_err;
endmodule
